// File: rtl/matmul_tile_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// matmul_tile_mem_ctrl_pkg
// Shared definitions for the tiled matmul host memory controller:
//   - default geometry (element width, building-block size, address width,
//     tile count, bank-select width)
//   - host command encodings
//   - controller FSM state encoding
//   - fixed host read latency (accept cycle to rd_valid)
// No ports; imported by matmul_tile_mem_ctrl and mem_ctrl_rd_pipe.
// ---------------------------------------------------------------------------
package matmul_tile_mem_ctrl_pkg;

  localparam int DWIDTH_DEF          = 16;
  localparam int BB_MAT_MUL_SIZE_DEF = 32;
  localparam int AWIDTH_DEF          = 7;
  localparam int NUM_TILES_DEF       = 2;
  localparam int BANK_W_DEF          = 3;

  // Cycles from an accepted READ_C to its rd_valid pulse.
  localparam int READ_LATENCY = 3;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'd0,
    CMD_WRITE_A = 2'd1,
    CMD_WRITE_B = 2'd2,
    CMD_READ_C  = 2'd3
  } host_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/matmul_tile_mem_ctrl_rd_pipe.sv
// ---------------------------------------------------------------------------
// mem_ctrl_rd_pipe
// Host C-read return path. Carries valid, bank index and bank-legal flag
// alongside the C RAM access so the correct bank word can be picked once the
// RAM output is available; the selected word is registered onto rd_data.
// Ports:
//   clk, reset_n  clock, synchronous active-low reset
//   rd_req        a READ_C was accepted this cycle
//   rd_bank       bank index of that read
//   rd_bank_ok    bank index is below NUM_TILES
//   c_rdata       all C bank read words (1-cycle RAM latency)
//   rd_valid      read data valid pulse (READ_LATENCY after rd_req)
//   rd_data       selected bank word, zero for an illegal bank
//   pipe_busy     some read is still travelling through the pipe
// ---------------------------------------------------------------------------
module mem_ctrl_rd_pipe
  import matmul_tile_mem_ctrl_pkg::*;
#(
  parameter int NUM_TILES = NUM_TILES_DEF,
  parameter int BANK_W    = BANK_W_DEF,
  parameter int WORD_W    = DWIDTH_DEF * BB_MAT_MUL_SIZE_DEF
)(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        rd_req,
  input  logic [BANK_W-1:0]           rd_bank,
  input  logic                        rd_bank_ok,
  input  logic [NUM_TILES*WORD_W-1:0] c_rdata,
  output logic                        rd_valid,
  output logic [WORD_W-1:0]           rd_data,
  output logic                        pipe_busy
);

  // The final output register is the last latency stage, so the tag
  // pipe only needs READ_LATENCY-1 stages in front of it.
  localparam int STAGES = READ_LATENCY - 1;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] ok;
  logic [BANK_W-1:0] bank [STAGES];
  logic [WORD_W-1:0] sel_word;

  // The last tag stage lines up with the cycle the C RAM presents data.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (bank[STAGES-1] == BANK_W'(i)) begin
        sel_word = c_rdata[i*WORD_W +: WORD_W];
      end
    end
  end

  // Tag shift pipe and registered output mux.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld      <= '0;
      ok       <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        bank[k] <= '0;
      end
    end else begin
      vld[0]  <= rd_req;
      ok[0]   <= rd_bank_ok;
      bank[0] <= rd_bank;
      for (int k = 1; k < STAGES; k++) begin
        vld[k]  <= vld[k-1];
        ok[k]   <= ok[k-1];
        bank[k] <= bank[k-1];
      end
      rd_valid <= vld[STAGES-1];
      rd_data  <= (vld[STAGES-1] && ok[STAGES-1]) ? sel_word : '0;
    end
  end

  assign pipe_busy = (|vld) || rd_valid;

endmodule

// File: rtl/matmul_tile_mem_ctrl.sv
// ---------------------------------------------------------------------------
// matmul_tile_mem_ctrl
// Host-side memory controller for a tiled systolic matmul. Arbitrates host
// writes into the A/B banks and host reads from the C banks, sequences a
// compute run (start -> COMPUTE -> DRAIN -> DONE) and generates C write
// addresses while the array streams results.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   host_valid/ready/cmd/bank/
//   host_addr/wdata              host transaction interface
//   rd_valid, rd_data            C read return (fixed latency 3)
//   start, busy, done_pulse      compute request / status
//   err_bank, err_c_wrap         sticky error flags
//   start_mat_mul, done_mat_mul  array handshake
//   arr_a_addr, arr_b_addr       array-driven A/B addresses
//   c_wvalid                     array C row valid
//   a/b/c_addr, a/b/c_we         registered bank addresses / write enables
//   a_wdata, b_wdata             registered host write word
//   c_rdata                      C bank read words
// ---------------------------------------------------------------------------
module matmul_tile_mem_ctrl
  import matmul_tile_mem_ctrl_pkg::*;
#(
  parameter int DWIDTH          = DWIDTH_DEF,
  parameter int BB_MAT_MUL_SIZE = BB_MAT_MUL_SIZE_DEF,
  parameter int AWIDTH          = AWIDTH_DEF,
  parameter int NUM_TILES       = NUM_TILES_DEF,
  parameter int BANK_W          = BANK_W_DEF
)(
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        host_valid,
  output logic                                        host_ready,
  input  logic [1:0]                                  host_cmd,
  input  logic [BANK_W-1:0]                           host_bank,
  input  logic [AWIDTH-1:0]                           host_addr,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]           host_wdata,
  output logic                                        rd_valid,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]           rd_data,
  input  logic                                        start,
  output logic                                        busy,
  output logic                                        done_pulse,
  output logic                                        err_bank,
  output logic                                        err_c_wrap,
  output logic                                        start_mat_mul,
  input  logic                                        done_mat_mul,
  input  logic [NUM_TILES*AWIDTH-1:0]                 arr_a_addr,
  input  logic [NUM_TILES*AWIDTH-1:0]                 arr_b_addr,
  input  logic                                        c_wvalid,
  output logic [NUM_TILES*AWIDTH-1:0]                 a_addr,
  output logic [NUM_TILES*AWIDTH-1:0]                 b_addr,
  output logic [NUM_TILES*AWIDTH-1:0]                 c_addr,
  output logic [NUM_TILES-1:0]                        a_we,
  output logic [NUM_TILES-1:0]                        b_we,
  output logic [NUM_TILES-1:0]                        c_we,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]           a_wdata,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]           b_wdata,
  input  logic [NUM_TILES*BB_MAT_MUL_SIZE*DWIDTH-1:0] c_rdata
);

  localparam int WORD_W = BB_MAT_MUL_SIZE * DWIDTH;
  // One extra bit so NUM_TILES == 2^BANK_W is representable.
  localparam logic [BANK_W:0] NT_LIMIT = (BANK_W+1)'(NUM_TILES);

  ctrl_state_e       state;
  logic              start_pending;
  logic              drain_cnt;
  logic [AWIDTH-1:0] c_cnt;
  logic [WORD_W-1:0] wdata_q;
  logic              pipe_busy;
  logic              start_take;
  logic              accept;
  logic              bank_ok;
  logic              wr_any;
  logic              wr_a;
  logic              wr_b;
  logic              rd_c;
  logic              c_wr;

  // A pending start is only taken once no host read is in flight, and host
  // transactions are refused in that cycle so none can sneak in behind it.
  assign bank_ok    = {1'b0, host_bank} < NT_LIMIT;
  assign start_take = start_pending && !pipe_busy;
  assign host_ready = (state == ST_IDLE) && !start_take;
  assign accept     = host_valid && host_ready;
  assign wr_any     = accept && (host_cmd == CMD_WRITE_A || host_cmd == CMD_WRITE_B);
  assign wr_a       = accept && (host_cmd == CMD_WRITE_A) && bank_ok;
  assign wr_b       = accept && (host_cmd == CMD_WRITE_B) && bank_ok;
  assign rd_c       = accept && (host_cmd == CMD_READ_C);
  assign c_wr       = (state == ST_COMPUTE) && c_wvalid;

  // Compute sequencing FSM. DRAIN lasts two cycles so the last c_we issued
  // in COMPUTE has reached the C banks before done_pulse is raised.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      start_pending <= 1'b0;
      drain_cnt     <= 1'b0;
      busy          <= 1'b0;
      start_mat_mul <= 1'b0;
      done_pulse    <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_take) begin
            state         <= ST_COMPUTE;
            start_pending <= 1'b0;
            busy          <= 1'b1;
            start_mat_mul <= 1'b1;
          end else if (start) begin
            start_pending <= 1'b1;
          end
        end
        ST_COMPUTE: begin
          if (done_mat_mul) begin
            state         <= ST_DRAIN;
            start_mat_mul <= 1'b0;
            drain_cnt     <= 1'b0;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            state      <= ST_DONE;
            done_pulse <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A/B bank ports: follow the array addresses one cycle late unless a host
  // write claims a bank for a single cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_addr   <= '0;
      b_addr   <= '0;
      a_we     <= '0;
      b_we     <= '0;
      wdata_q  <= '0;
      err_bank <= 1'b0;
    end else begin
      a_addr <= arr_a_addr;
      b_addr <= arr_b_addr;
      a_we   <= '0;
      b_we   <= '0;
      if (accept && host_cmd != CMD_NOP && !bank_ok) begin
        err_bank <= 1'b1;
      end
      if (wr_any) begin
        wdata_q <= host_wdata;
      end
      for (int i = 0; i < NUM_TILES; i++) begin
        if (host_bank == BANK_W'(i)) begin
          if (wr_a) begin
            a_addr[i*AWIDTH +: AWIDTH] <= host_addr;
            a_we[i]                    <= 1'b1;
          end
          if (wr_b) begin
            b_addr[i*AWIDTH +: AWIDTH] <= host_addr;
            b_we[i]                    <= 1'b1;
          end
        end
      end
    end
  end

  // C bank ports: the array result stream owns them in COMPUTE (all banks
  // written at the running counter), host reads own them in IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      c_cnt      <= '0;
      c_we       <= '0;
      c_addr     <= '0;
      err_c_wrap <= 1'b0;
    end else begin
      c_we <= '0;
      if (start_take) begin
        c_cnt <= '0;
      end else if (c_wr) begin
        c_we  <= '1;
        c_cnt <= c_cnt + AWIDTH'(1);
        if (&c_cnt) begin
          err_c_wrap <= 1'b1;
        end
        for (int i = 0; i < NUM_TILES; i++) begin
          c_addr[i*AWIDTH +: AWIDTH] <= c_cnt;
        end
      end
      for (int i = 0; i < NUM_TILES; i++) begin
        if (rd_c && bank_ok && host_bank == BANK_W'(i)) begin
          c_addr[i*AWIDTH +: AWIDTH] <= host_addr;
        end
      end
    end
  end

  assign a_wdata = wdata_q;
  assign b_wdata = wdata_q;

  mem_ctrl_rd_pipe #(
    .NUM_TILES (NUM_TILES),
    .BANK_W    (BANK_W),
    .WORD_W    (WORD_W)
  ) u_rd_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_req     (rd_c),
    .rd_bank    (host_bank),
    .rd_bank_ok (bank_ok),
    .c_rdata    (c_rdata),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .pipe_busy  (pipe_busy)
  );

endmodule

// File: tb/tb_matmul_tile_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_matmul_tile_mem_ctrl
// Self-checking bench for matmul_tile_mem_ctrl. Models the C banks as a
// behavioural 1-cycle-latency RAM and predicts host-visible behaviour from
// transaction-level rules (reads return stored words three cycles after
// acceptance, writes show up on the addressed bank for one cycle, etc.).
// No ports.
// ---------------------------------------------------------------------------
module tb_matmul_tile_mem_ctrl;

  localparam int DW    = 16;
  localparam int BB    = 32;
  localparam int W     = DW * BB;
  localparam int AW    = 7;
  localparam int NT    = 2;
  localparam int BW    = 3;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } rd_exp_t;

  logic             clk;
  logic             reset_n;
  logic             host_valid;
  logic             host_ready;
  logic [1:0]       host_cmd;
  logic [BW-1:0]    host_bank;
  logic [AW-1:0]    host_addr;
  logic [W-1:0]     host_wdata;
  logic             rd_valid;
  logic [W-1:0]     rd_data;
  logic             start;
  logic             busy;
  logic             done_pulse;
  logic             err_bank;
  logic             err_c_wrap;
  logic             start_mat_mul;
  logic             done_mat_mul;
  logic [NT*AW-1:0] arr_a_addr;
  logic [NT*AW-1:0] arr_b_addr;
  logic             c_wvalid;
  logic [NT*AW-1:0] a_addr;
  logic [NT*AW-1:0] b_addr;
  logic [NT*AW-1:0] c_addr;
  logic [NT-1:0]    a_we;
  logic [NT-1:0]    b_we;
  logic [NT-1:0]    c_we;
  logic [W-1:0]     a_wdata;
  logic [W-1:0]     b_wdata;
  logic [NT*W-1:0]  c_rdata;

  logic [W-1:0]     cmem [NT][DEPTH];
  rd_exp_t          rd_q [$];
  logic [W-1:0]     m_wdata;
  logic             m_err_bank;
  int               cyc;
  int               last_rd_due;
  int               checks;
  int               errors;

  matmul_tile_mem_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .host_cmd      (host_cmd),
    .host_bank     (host_bank),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .start         (start),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .err_bank      (err_bank),
    .err_c_wrap    (err_c_wrap),
    .start_mat_mul (start_mat_mul),
    .done_mat_mul  (done_mat_mul),
    .arr_a_addr    (arr_a_addr),
    .arr_b_addr    (arr_b_addr),
    .c_wvalid      (c_wvalid),
    .a_addr        (a_addr),
    .b_addr        (b_addr),
    .c_addr        (c_addr),
    .a_we          (a_we),
    .b_we          (b_we),
    .c_we          (c_we),
    .a_wdata       (a_wdata),
    .b_wdata       (b_wdata),
    .c_rdata       (c_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural C banks: registered read of whatever address the DUT drives.
  always @(posedge clk) begin
    for (int b = 0; b < NT; b++) begin
      c_rdata[b*W +: W] <= cmem[b][int'(c_addr[b*AW +: AW])];
    end
  end

  // Hang guard.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W/32; i++) begin
      w[i*32 +: 32] = $urandom;
    end
    return w;
  endfunction

  function automatic logic [NT*AW-1:0] rep_addr(input int v);
    logic [NT*AW-1:0] r;
    for (int i = 0; i < NT; i++) begin
      r[i*AW +: AW] = AW'(v % DEPTH);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock. Expectations are derived from the inputs presented
  // before the edge; outputs are sampled 1 time unit after it.
  task automatic step_cycle();
    logic [NT*AW-1:0] ea;
    logic [NT*AW-1:0] eb;
    logic [NT-1:0]    ewa;
    logic [NT-1:0]    ewb;
    rd_exp_t          e;
    arr_a_addr = (NT*AW)'($urandom);
    arr_b_addr = (NT*AW)'($urandom);
    ea  = arr_a_addr;
    eb  = arr_b_addr;
    ewa = '0;
    ewb = '0;
    if (host_valid) begin
      checkOutput("host_ready_at_request", W'(host_ready), W'(1'b1));
      if (host_cmd != 2'd0 && int'(host_bank) >= NT) m_err_bank = 1'b1;
      if (host_cmd == 2'd1 || host_cmd == 2'd2) m_wdata = host_wdata;
      if (int'(host_bank) < NT) begin
        if (host_cmd == 2'd1) begin
          ea[int'(host_bank)*AW +: AW] = host_addr;
          ewa[int'(host_bank)] = 1'b1;
        end
        if (host_cmd == 2'd2) begin
          eb[int'(host_bank)*AW +: AW] = host_addr;
          ewb[int'(host_bank)] = 1'b1;
        end
      end
      if (host_cmd == 2'd3) begin
        e.due  = cyc + 3;
        e.data = (int'(host_bank) < NT) ? cmem[int'(host_bank)][int'(host_addr)] : '0;
        rd_q.push_back(e);
        last_rd_due = e.due;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("a_we", W'(a_we), W'(ewa));
    checkOutput("b_we", W'(b_we), W'(ewb));
    checkOutput("a_addr", W'(a_addr), W'(ea));
    checkOutput("b_addr", W'(b_addr), W'(eb));
    checkOutput("a_wdata", a_wdata, m_wdata);
    checkOutput("b_wdata", b_wdata, m_wdata);
    checkOutput("err_bank", W'(err_bank), W'(m_err_bank));
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      checkOutput("rd_valid", W'(rd_valid), W'(1'b1));
      checkOutput("rd_data", rd_data, rd_q[0].data);
      void'(rd_q.pop_front());
    end else begin
      checkOutput("rd_valid_quiet", W'(rd_valid), W'(1'b0));
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cmd, input int bank, input int addr,
                               input logic [W-1:0] data);
    host_cmd   = cmd;
    host_bank  = BW'(bank);
    host_addr  = AW'(addr);
    host_wdata = data;
    host_valid = 1'b1;
    step_cycle();
    host_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_n      = 1'b0;
    host_valid   = 1'b0;
    start        = 1'b0;
    c_wvalid     = 1'b0;
    done_mat_mul = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    cyc       += n;
    reset_n    = 1'b1;
    m_wdata    = '0;
    m_err_bank = 1'b0;
    rd_q.delete();
  endtask

  // Directed and randomised test sequence.
  initial begin
    int n;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    last_rd_due  = 0;
    m_wdata      = '0;
    m_err_bank   = 1'b0;
    reset_n      = 1'b0;
    host_valid   = 1'b0;
    host_cmd     = 2'd0;
    host_bank    = '0;
    host_addr    = '0;
    host_wdata   = '0;
    start        = 1'b0;
    done_mat_mul = 1'b0;
    c_wvalid     = 1'b0;
    arr_a_addr   = '0;
    arr_b_addr   = '0;
    c_rdata      = '0;
    for (int b = 0; b < NT; b++) begin
      for (int a = 0; a < DEPTH; a++) begin
        cmem[b][a] = rand_word();
      end
    end
    cmem[0][5] = {(W/16){16'h1234}};

    $display("[TB] reset");
    do_reset(4);
    checkOutput("rst_host_ready", W'(host_ready), W'(1'b1));
    checkOutput("rst_busy", W'(busy), W'(1'b0));
    checkOutput("rst_rd_valid", W'(rd_valid), W'(1'b0));
    checkOutput("rst_rd_data", rd_data, '0);
    checkOutput("rst_a_we", W'(a_we), W'(0));
    checkOutput("rst_b_we", W'(b_we), W'(0));
    checkOutput("rst_c_we", W'(c_we), W'(0));
    checkOutput("rst_a_addr", W'(a_addr), W'(0));
    checkOutput("rst_err_bank", W'(err_bank), W'(1'b0));
    checkOutput("rst_err_c_wrap", W'(err_c_wrap), W'(1'b0));
    checkOutput("rst_start_mat_mul", W'(start_mat_mul), W'(1'b0));
    checkOutput("rst_done_pulse", W'(done_pulse), W'(1'b0));

    $display("[TB] directed write A / read C");
    applyStimulus(2'd1, 1, 5, {(W/16){16'hABCD}});
    checkOutput("wr_a_we_bank1", W'(a_we), W'(2'b10));
    checkOutput("wr_a_addr_bank1", W'(a_addr[AW +: AW]), W'(5));
    applyStimulus(2'd3, 0, 5, '0);
    repeat (3) step_cycle();

    $display("[TB] back-to-back reads");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'd3, i % 2, i, '0);
    end
    repeat (4) step_cycle();

    $display("[TB] illegal bank");
    applyStimulus(2'd2, 3, 9, rand_word());
    applyStimulus(2'd3, 3, 9, '0);
    repeat (4) step_cycle();
    checkOutput("err_bank_sticky", W'(err_bank), W'(1'b1));

    $display("[TB] random host traffic");
    for (int k = 0; k < 80; k++) begin
      host_cmd   = 2'($urandom_range(0, 3));
      host_bank  = (host_cmd == 2'd0) ? BW'($urandom_range(0, NT-1))
                                      : BW'($urandom_range(0, NT));
      host_addr  = AW'($urandom);
      host_wdata = rand_word();
      host_valid = ($urandom_range(0, 3) != 0);
      step_cycle();
    end
    host_valid = 1'b0;
    repeat (4) step_cycle();

    $display("[TB] start behind a read");
    applyStimulus(2'd3, 1, 17, '0);
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (host_ready === 1'b0) break;
      step_cycle();
    end
    checkOutput("start_take_cycle", W'(cyc), W'(last_rd_due + 1));
    checkOutput("start_mat_mul_before", W'(start_mat_mul), W'(1'b0));
    step_cycle();
    checkOutput("start_mat_mul_on", W'(start_mat_mul), W'(1'b1));
    checkOutput("busy_on", W'(busy), W'(1'b1));
    checkOutput("host_ready_compute", W'(host_ready), W'(1'b0));
    for (int i = 0; i < 3; i++) begin
      c_wvalid = 1'b1;
      step_cycle();
      c_wvalid = 1'b0;
      checkOutput("c_we_pulse", W'(c_we), W'({NT{1'b1}}));
      checkOutput("c_addr_seq", W'(c_addr), W'(rep_addr(i)));
      step_cycle();
      checkOutput("c_we_gap", W'(c_we), W'(0));
    end
    done_mat_mul = 1'b1;
    step_cycle();
    done_mat_mul = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      if (done_pulse === 1'b1) break;
      step_cycle();
      n++;
    end
    checkOutput("done_latency", W'(n), W'(3));
    checkOutput("busy_at_done", W'(busy), W'(1'b1));
    step_cycle();
    checkOutput("done_pulse_width", W'(done_pulse), W'(1'b0));
    checkOutput("busy_after_done", W'(busy), W'(1'b0));
    checkOutput("host_ready_after_done", W'(host_ready), W'(1'b1));
    checkOutput("start_mat_mul_after", W'(start_mat_mul), W'(1'b0));

    $display("[TB] C address wrap");
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    checkOutput("host_ready_take", W'(host_ready), W'(1'b0));
    step_cycle();
    checkOutput("start_mat_mul_wrap", W'(start_mat_mul), W'(1'b1));
    c_wvalid = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      step_cycle();
      checkOutput("wrap_c_we", W'(c_we), W'({NT{1'b1}}));
      checkOutput("wrap_c_addr", W'(c_addr), W'(rep_addr(i)));
      checkOutput("wrap_err", W'(err_c_wrap), W'(i + 1 >= DEPTH));
    end
    c_wvalid = 1'b0;

    $display("[TB] reset during compute");
    do_reset(2);
    checkOutput("abort_start_mat_mul", W'(start_mat_mul), W'(1'b0));
    checkOutput("abort_busy", W'(busy), W'(1'b0));
    checkOutput("abort_err_c_wrap", W'(err_c_wrap), W'(1'b0));
    checkOutput("abort_err_bank", W'(err_bank), W'(1'b0));
    checkOutput("abort_host_ready", W'(host_ready), W'(1'b1));
    for (int i = 0; i < 6; i++) begin
      step_cycle();
      checkOutput("abort_no_done", W'(done_pulse), W'(1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
